pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed-field pipeline stage registers.
- A chain of DEPTH registered stages, each carrying a WIDTH-bit payload plus a valid bit.
- Upstream and downstream use valid/ready handshakes; global stall and flush inputs are kept, and a per-stage kill vector is added.
- Empty stages (bubbles) collapse while the output is back-pressured.
- Used between datapath stages wherever more than one register slot or elastic buffering is needed.

Parameters:
- WIDTH, 32: payload bits per stage.
- DEPTH, 2: number of stages, >= 1. Stage 0 is the input side; stage DEPTH-1 drives the output.
- RESET_DATA, 0: payload value loaded on reset, flush, or bubble load.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  global freeze: no stage moves, no handshake completes.
- flush  in  1  synchronous invalidate of all stages.
- kill  in  DEPTH  per-stage invalidate of the current contents of stage i.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds a live entry.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- occupancy  out  clog2(DEPTH+1)  count of valid stages (registered state, combinational count).

Behaviour:
- Reset is synchronous and active-high on clk; it is the only reset.
- Priority at each edge: reset > flush > stall > normal.
- reset or flush: every valid[i] <= 0 and every data[i] <= RESET_DATA. During a flush cycle in_ready = 0, so the input is dropped and not accepted.
- Reset values: out_valid = 0, out_data = RESET_DATA, occupancy = 0, in_ready = 0 while reset is high.
- Effective valid: live[i] = valid[i] & !kill[i].
- Advance chain (combinational), evaluated when not stalled and not flushing:
  - adv[DEPTH-1] = !live[DEPTH-1] | out_ready.
  - adv[i] = !live[i] | adv[i+1], for i < DEPTH-1.
- Stage update, for i > 0, when adv[i] = 1:
  - valid[i] <= live[i-1]
  - data[i] <= (live[i-1] ? data[i-1] : RESET_DATA)
- Stage 0 update, when adv[0] = 1:
  - valid[0] <= in_valid
  - data[0] <= (in_valid ? in_data : RESET_DATA)
- When adv[i] = 0 (not stalled, not flushing), stage i holds its data and valid[i] <= live[i]. A killed, non-advancing entry is thus cleared.
- in_ready = adv[0] & !stall & !flush & !reset. It does not depend on in_valid.
- out_valid = live[DEPTH-1] & !stall & !flush. out_data = data[DEPTH-1] is always driven.
- Latency: an accepted entry reaches out_valid DEPTH cycles after acceptance if the chain is empty and out_ready is held. Throughput is 1 entry/cycle.
- Stall: all state holds, kill is ignored, in_ready = 0, out_valid = 0. Nothing is lost.
- Back-pressure (out_ready = 0, no stall): entries behind bubbles keep moving forward. The chain holds up to DEPTH entries. in_ready drops only when all DEPTH stages are live.
- Simultaneous kill[DEPTH-1] and out_ready: the entry is dropped, not delivered, and does not count as a transfer.
- Kill on an empty stage has no effect.
- DEPTH = 1 degenerates to a single register with a full-bandwidth ready path: in_ready = !live[0] | out_ready.
- Reset or flush asserted mid-transfer: the handshake does not complete and all stages are empty on the next cycle.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- With the macro: adds output port perf_stall_cycles (32 bits, reset to 0). It increments by one on every cycle with (stall) or (live[DEPTH-1] & !out_ready & !flush), saturates at 0xFFFFFFFF, and is cleared by reset only, not by flush.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- DEPTH=2, out_ready=1, push 0x11, 0x22, 0x33 on consecutive cycles -> out_valid with 0x11, 0x22, 0x33 on cycles 2, 3, 4; in_ready held at 1 throughout.
- DEPTH=3, out_ready=0, push 0xA, then one idle cycle, then 0xB, 0xC -> occupancy reaches 3 with no gap; in_ready=0 after the third accept; release out_ready -> 0xA, 0xB, 0xC emerge in order.
- Chain holding 0x5 and 0x6, stall=1 for 4 cycles with out_ready=1 and in_valid=1 -> in_ready=0 and out_valid=0 for those 4 cycles, no state change; after release, 0x5 and 0x6 are delivered.
- Chain full (DEPTH=2), flush=1 for one cycle with in_valid=1 and in_data=0x77 -> next cycle occupancy=0, out_data=RESET_DATA, and 0x77 never appears.
- DEPTH=3 holding 0x1, 0x2, 0x3, out_ready=0, kill=3'b010 for one cycle -> 0x2 dropped, occupancy=2; later output order is 0x1, 0x3.
- PIPE_STAGE_CHAIN_PERF_EN defined: 5 cycles of back-pressure plus 2 stall cycles -> perf_stall_cycles=7; a subsequent flush leaves it at 7; reset returns it to 0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready register chain whose bubbles collapse under back-pressure.
// Optional macro PIPE_STAGE_CHAIN_PERF_EN adds the saturating perf_stall_cycles counter port.
module pipe_stage_chain #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [DEPTH-1:0]             kill,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cycles
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] nxt_valid;
    logic [WIDTH-1:0] nxt_data [DEPTH];

    always_comb begin
        live = valid_q & ~kill;
    end

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !live[DEPTH-1] || out_ready;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            adv[DEPTH-2-i] = !live[DEPTH-2-i] || adv[DEPTH-1-i];
        end
    end

    always_comb begin
        nxt_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            nxt_data[i] = RESET_DATA;
        end
        nxt_valid[0] = in_valid;
        nxt_data[0]  = in_valid ? in_data : RESET_DATA;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            nxt_valid[i] = live[i-1];
            nxt_data[i]  = live[i-1] ? data_q[i-1] : RESET_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_DATA;
            end
        end else if (!stall) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= nxt_valid[i];
                    data_q[i]  <= nxt_data[i];
                end else begin
                    valid_q[i] <= live[i];
                end
            end
        end
    end

    always_comb begin
        in_ready  = adv[0] && !stall && !flush && !reset;
        out_valid = live[DEPTH-1] && !stall && !flush;
        out_data  = data_q[DEPTH-1];
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Counts frozen cycles and cycles where a live output is refused; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if ((stall || (live[DEPTH-1] && !out_ready && !flush))
                     && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: DEPTH 1/2/3 instances share stimulus against a slot-level model.
// Perf-counter checks are compiled in with PIPE_STAGE_CHAIN_PERF_EN.
module tb_pipe_stage_chain;

    localparam logic [7:0] RD = 8'hE5;

    logic       clk;
    logic       reset, stall, flush, in_valid, out_ready;
    logic [2:0] kill3;
    logic [7:0] in_data;

    logic       ov [3];
    logic       ir [3];
    logic [7:0] od [3];
    logic [0:0] occ1;
    logic [1:0] occ2, occ3;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] pf [3];
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: per instance, an array of slots (index 0 = input side)
    int          dep [3] = '{1, 2, 3};
    bit          mv  [3][3];
    logic [7:0]  md  [3][3];
    logic [31:0] mp  [3];

    pipe_stage_chain #(.WIDTH(8), .DEPTH(1), .RESET_DATA(RD)) u_d1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .kill(kill3[0:0]),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ1)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        , .perf_stall_cycles(pf[0])
`endif
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .RESET_DATA(RD)) u_d2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .kill(kill3[1:0]),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ2)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        , .perf_stall_cycles(pf[1])
`endif
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(3), .RESET_DATA(RD)) u_d3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .kill(kill3),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .occupancy(occ3)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        , .perf_stall_cycles(pf[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int get_occ(int k);
        case (k)
            0:       return int'(occ1);
            1:       return int'(occ2);
            default: return int'(occ3);
        endcase
    endfunction

    function automatic bit m_live(int k, int i);
        return mv[k][i] && !kill3[i];
    endfunction

    function automatic bit e_in_ready(int k);
        if (reset || stall || flush) return 1'b0;
        if (out_ready) return 1'b1;
        for (int i = 0; i < dep[k]; i++) if (!m_live(k, i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit e_out_valid(int k);
        return !stall && !flush && m_live(k, dep[k] - 1);
    endfunction

    function automatic int e_occ(int k);
        int n = 0;
        for (int i = 0; i < dep[k]; i++) n += int'(mv[k][i]);
        return n;
    endfunction

    // Every slot moves forward if some slot at or beyond it is free, or the output drains.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int         d;
            bit         lv [3];
            bit         nv [3];
            logic [7:0] nd [3];
            d = dep[k];
            if (reset) mp[k] = 32'd0;
            else if ((stall || (m_live(k, d-1) && !out_ready && !flush)) && mp[k] != 32'hFFFF_FFFF)
                mp[k] = mp[k] + 32'd1;
            if (reset || flush) begin
                for (int i = 0; i < 3; i++) begin mv[k][i] = 1'b0; md[k][i] = RD; end
            end else if (!stall) begin
                for (int i = 0; i < d; i++) lv[i] = m_live(k, i);
                for (int i = 0; i < d; i++) begin
                    bit go = out_ready;
                    for (int j = i; j < d; j++) if (!lv[j]) go = 1'b1;
                    if (!go) begin
                        nv[i] = lv[i]; nd[i] = md[k][i];
                    end else if (i == 0) begin
                        nv[i] = in_valid; nd[i] = in_valid ? in_data : RD;
                    end else begin
                        nv[i] = lv[i-1]; nd[i] = lv[i-1] ? md[k][i-1] : RD;
                    end
                end
                for (int i = 0; i < d; i++) begin mv[k][i] = nv[i]; md[k][i] = nd[i]; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        reset = 0; stall = 0; flush = 0; kill3 = '0;
        in_valid = 0; in_data = '0; out_ready = 0;
    endtask

    task automatic clear_chain();
        set_idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1; in_valid = 1; in_data = 8'h3C; out_ready = 1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b0) begin failures++; $display("FAIL reset_in_ready k=%0d got=%b exp=0", k, ir[k]); end
        end
        set_idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, ov[k]); end
            checks++;
            if (od[k] !== RD) begin failures++; $display("FAIL reset_out_data k=%0d got=%h exp=%h", k, od[k], RD); end
            checks++;
            if (get_occ(k) != 0) begin failures++; $display("FAIL reset_occupancy k=%0d got=%0d exp=0", k, get_occ(k)); end
            checks++;
            if (ir[k] !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready k=%0d got=%b exp=1", k, ir[k]); end
        end
    endtask

    task automatic test_throughput();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        clear_chain();
        for (int c = 0; c < 6; c++) begin
            out_ready = 1;
            in_valid  = (c < 3);
            in_data   = (c < 3) ? vals[c] : 8'h00;
            #1;
            checks++;
            if (ir[1] !== 1'b1) begin failures++; $display("FAIL thru_in_ready c=%0d got=%b exp=1", c, ir[1]); end
            checks++;
            if (ov[1] !== (c >= 2 && c <= 4)) begin
                failures++; $display("FAIL thru_out_valid c=%0d got=%b exp=%b", c, ov[1], (c >= 2 && c <= 4));
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (od[1] !== vals[c-2]) begin failures++; $display("FAIL thru_out_data c=%0d got=%h exp=%h", c, od[1], vals[c-2]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit         iv  [5] = '{1, 0, 1, 1, 1};
        logic [7:0] dat [5] = '{8'h0A, 8'h00, 8'h0B, 8'h0C, 8'h0D};
        int         eocc[5] = '{0, 1, 1, 2, 3};
        logic [7:0] order[3] = '{8'h0A, 8'h0B, 8'h0C};
        clear_chain();
        for (int c = 0; c < 5; c++) begin
            out_ready = 0; in_valid = iv[c]; in_data = dat[c];
            #1;
            checks++;
            if (get_occ(2) != eocc[c]) begin failures++; $display("FAIL bp_occupancy c=%0d got=%0d exp=%0d", c, get_occ(2), eocc[c]); end
            checks++;
            if (ir[2] !== (c < 4)) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, ir[2], (c < 4)); end
            tick();
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ov[2] !== (c < 3)) begin failures++; $display("FAIL bp_drain_valid c=%0d got=%b exp=%b", c, ov[2], (c < 3)); end
            if (c < 3) begin
                checks++;
                if (od[2] !== order[c]) begin failures++; $display("FAIL bp_drain_data c=%0d got=%h exp=%h", c, od[2], order[c]); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        clear_chain();
        out_ready = 0;
        in_valid = 1; in_data = 8'h05; tick();
        in_data = 8'h06; tick();
        stall = 1; out_ready = 1; in_valid = 1; in_data = 8'h99;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ir[1] !== 1'b0) begin failures++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, ir[1]); end
            checks++;
            if (ov[1] !== 1'b0) begin failures++; $display("FAIL stall_out_valid c=%0d got=%b exp=0", c, ov[1]); end
            checks++;
            if (get_occ(1) != 2 || od[1] !== 8'h05) begin
                failures++; $display("FAIL stall_hold c=%0d got occ=%0d data=%h exp occ=2 data=05", c, get_occ(1), od[1]);
            end
            tick();
        end
        stall = 0; in_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== (c == 0 ? 8'h05 : 8'h06)) begin
                failures++; $display("FAIL stall_release c=%0d got v=%b d=%h exp v=1 d=%h", c, ov[1], od[1], (c == 0 ? 8'h05 : 8'h06));
            end
            tick();
        end
    endtask

    task automatic test_flush();
        clear_chain();
        out_ready = 0;
        in_valid = 1; in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        flush = 1; in_data = 8'h77;
        #1;
        checks++;
        if (ir[1] !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", ir[1]); end
        tick();
        flush = 0; in_valid = 0;
        #1;
        checks++;
        if (get_occ(1) != 0) begin failures++; $display("FAIL flush_occupancy got=%0d exp=0", get_occ(1)); end
        checks++;
        if (od[1] !== RD) begin failures++; $display("FAIL flush_out_data got=%h exp=%h", od[1], RD); end
        out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ov[1] !== 1'b0) begin failures++; $display("FAIL flush_no_ghost c=%0d got v=%b d=%h exp v=0", c, ov[1], od[1]); end
            tick();
        end
    endtask

    task automatic test_kill();
        clear_chain();
        out_ready = 0; in_valid = 1;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        in_data = 8'h03; tick();
        in_valid = 0; kill3 = 3'b010;
        tick();
        kill3 = '0;
        #1;
        checks++;
        if (get_occ(2) != 2) begin failures++; $display("FAIL kill_occupancy got=%0d exp=2", get_occ(2)); end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ov[2] !== (c < 2)) begin failures++; $display("FAIL kill_order_valid c=%0d got=%b exp=%b", c, ov[2], (c < 2)); end
            if (c < 2) begin
                checks++;
                if (od[2] !== (c == 0 ? 8'h01 : 8'h03)) begin
                    failures++; $display("FAIL kill_order_data c=%0d got=%h exp=%h", c, od[2], (c == 0 ? 8'h01 : 8'h03));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        clear_chain();
        for (int c = 0; c < 3000; c++) begin
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            kill3     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 9) < 5);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== e_in_ready(k)) begin failures++; $display("FAIL rnd_in_ready c=%0d k=%0d got=%b exp=%b", c, k, ir[k], e_in_ready(k)); end
                checks++;
                if (ov[k] !== e_out_valid(k)) begin failures++; $display("FAIL rnd_out_valid c=%0d k=%0d got=%b exp=%b", c, k, ov[k], e_out_valid(k)); end
                checks++;
                if (od[k] !== md[k][dep[k]-1]) begin failures++; $display("FAIL rnd_out_data c=%0d k=%0d got=%h exp=%h", c, k, od[k], md[k][dep[k]-1]); end
                checks++;
                if (get_occ(k) != e_occ(k)) begin failures++; $display("FAIL rnd_occupancy c=%0d k=%0d got=%0d exp=%0d", c, k, get_occ(k), e_occ(k)); end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
                checks++;
                if (pf[k] !== mp[k]) begin failures++; $display("FAIL rnd_perf c=%0d k=%0d got=%0d exp=%0d", c, k, pf[k], mp[k]); end
`endif
            end
            tick();
        end
        set_idle();
    endtask

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    task automatic test_perf();
        set_idle();
        reset = 1; tick(); reset = 0;
        in_valid = 1; in_data = 8'h42; tick();
        in_valid = 0; tick();
        for (int c = 0; c < 5; c++) tick();
        stall = 1; tick(); tick(); stall = 0;
        checks++;
        if (pf[1] !== 32'd7) begin failures++; $display("FAIL perf_count got=%0d exp=7", pf[1]); end
        flush = 1; tick(); flush = 0;
        checks++;
        if (pf[1] !== 32'd7) begin failures++; $display("FAIL perf_after_flush got=%0d exp=7", pf[1]); end
        reset = 1; tick(); reset = 0;
        checks++;
        if (pf[1] !== 32'd0) begin failures++; $display("FAIL perf_after_reset got=%0d exp=0", pf[1]); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            mp[k] = 32'd0;
            for (int i = 0; i < 3; i++) begin mv[k][i] = 1'b0; md[k][i] = RD; end
        end
        set_idle();
        test_reset();
        test_throughput();
        test_backpressure();
        test_stall();
        test_flush();
        test_kill();
        test_random();
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
